// File: rtl/stack_ptr_ctrl.sv
// stack_ptr_ctrl: downward-growing stack pointer with occupancy, bounds checks and sticky error flags
module stack_ptr_ctrl #(
  parameter int W = 16,
  parameter int DEPTH = 8,
  parameter logic [W-1:0] BASE = {{(W-1){1'b1}}, 1'b0},
  parameter int STEP = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_en,
  input  logic          pop_en,
  input  logic          load_en,
  input  logic [W-1:0]  load_val,
  input  logic          err_clr,
  output logic [W-1:0]  sp,
  output logic [W-1:0]  mem_addr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underflow,
  output logic          range_err
);
  localparam logic [W-1:0]  STEP_W = W'(STEP);
  localparam logic [W-1:0]  LIMIT = BASE - W'(DEPTH * STEP);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  logic [W-1:0]  sp_q, sp_d, diff;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d, underflow_q, underflow_d, range_err_q, range_err_d;
  logic          legal;
  assign full = count_q == DEPTH_C;
  assign empty = count_q == '0;
  assign sp = sp_q;
  assign count = count_q;
  assign overflow = overflow_q;
  assign underflow = underflow_q;
  assign range_err = range_err_q;
  always_comb begin
    diff = BASE - load_val;
    legal = load_val >= LIMIT && load_val <= BASE && diff % STEP_W == '0;
    sp_d = sp_q;
    count_d = count_q;
    mem_addr = sp_q;
    overflow_d = err_clr ? 1'b0 : overflow_q;
    underflow_d = err_clr ? 1'b0 : underflow_q;
    range_err_d = err_clr ? 1'b0 : range_err_q;
    if (load_en) begin
      if (legal) begin
        sp_d = load_val;
        count_d = CW'(diff / STEP_W);
      end else
        range_err_d = 1'b1;
    end else if (push_en && (!pop_en || empty)) begin
      // push+pop on an empty stack degrades to a plain push
      if (full)
        overflow_d = 1'b1;
      else begin
        mem_addr = sp_q - STEP_W;
        sp_d = sp_q - STEP_W;
        count_d = count_q + 1'b1;
      end
    end else if (pop_en && !push_en) begin
      if (empty)
        underflow_d = 1'b1;
      else begin
        sp_d = sp_q + STEP_W;
        count_d = count_q - 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= BASE;
      count_q <= '0;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      sp_q <= sp_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
      underflow_q <= underflow_d;
      range_err_q <= range_err_d;
    end
  end
endmodule
